// File: rtl/fast_accel_job_sched_pkg.sv
// Shared types, default widths and helpers for the fast_accel job scheduler.
package fast_accel_sched_pkg;

  typedef enum logic [2:0] {IDLE, START, RUN, RESP, DRAIN} sched_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ARG_W   = 32;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 50000;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fast_accel_job_sched_if.sv
// Request, core ap_ctrl_hs and completion-record signals of the job scheduler.
interface fast_accel_job_sched_if
  import fast_accel_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ARG_W   = DEF_ARG_W,
  parameter int CNT_W   = DEF_CNT_W
);
  localparam int IW = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*ARG_W-1:0] req_arg;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     core_ap_start;
  logic                     core_ap_ready;
  logic                     core_ap_done;
  logic                     core_ap_idle;
  logic [ARG_W-1:0]         core_arg;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [IW-1:0]            resp_id;
  logic [CNT_W-1:0]         resp_cycles;
  logic                     resp_timeout;
  logic                     busy;
  logic [CNT_W-1:0]         job_count;

  modport master (
    input  req_valid, req_arg, core_ap_ready, core_ap_done, core_ap_idle, resp_ready,
    output req_ready, core_ap_start, core_arg, resp_valid, resp_id, resp_cycles,
           resp_timeout, busy, job_count
  );

  modport slave (
    output req_valid, req_arg, core_ap_ready, core_ap_done, core_ap_idle, resp_ready,
    input  req_ready, core_ap_start, core_arg, resp_valid, resp_id, resp_cycles,
           resp_timeout, busy, job_count
  );

endinterface

// File: rtl/fast_accel_rr_arb.sv
// Combinational round-robin pick: first request at or above ptr, else lowest overall.
module fast_accel_rr_arb
  import fast_accel_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        any    = 1'b1;
      end
    end
    // wrap-around pass only runs when nothing was found above the pointer
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i]) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fast_accel_job_sched.sv
// Round-robin job scheduler driving one fast_accel ap_ctrl_hs invocation at a time,
// returning a completion record (id, latency, timeout) that stalls in RESP under backpressure.
module fast_accel_job_sched
  import fast_accel_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ARG_W   = DEF_ARG_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic ap_clk,
  input logic ap_rst_n,
  fast_accel_job_sched_if.master io
);
  localparam int IW = clog2_min1(NUM_REQ);

  sched_state_t      state, state_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]     gnt_idx, rr_ptr, cur_id;
  logic              gnt_any;
  logic [ARG_W-1:0]  arg_sel, arg_q;
  logic [CNT_W-1:0]  cnt, cnt_inc, job_cnt;
  logic              to_flag, to_hit, to_set;

  fast_accel_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req (io.req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign arg_sel = io.req_arg[gnt_idx*ARG_W +: ARG_W];
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign to_hit  = int'(cnt_inc) >= TIMEOUT;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // done sampled together with the timeout threshold counts as a normal completion
  always_comb begin
    state_nxt = state;
    to_set    = 1'b0;
    case (state)
      IDLE:  if (gnt_any) state_nxt = START;
      START: begin
        if (io.core_ap_ready && io.core_ap_done) state_nxt = RESP;
        else if (to_hit) begin
          state_nxt = RESP;
          to_set    = 1'b1;
        end
        else if (io.core_ap_ready) state_nxt = RUN;
      end
      RUN: begin
        if (io.core_ap_done) state_nxt = RESP;
        else if (to_hit) begin
          state_nxt = RESP;
          to_set    = 1'b1;
        end
      end
      RESP:  if (io.resp_ready) state_nxt = to_flag ? DRAIN : IDLE;
      DRAIN: if (io.core_ap_done || io.core_ap_idle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.req_ready     = (state == IDLE) ? gnt : '0;
    io.core_ap_start = (state == START);
    io.resp_valid    = (state == RESP);
    io.busy          = (state != IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      arg_q   <= '0;
      cur_id  <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      to_flag <= 1'b0;
      job_cnt <= '0;
    end else begin
      if (state == IDLE && gnt_any) begin
        arg_q   <= arg_sel;
        cur_id  <= gnt_idx;
        rr_ptr  <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        cnt     <= '0;
        to_flag <= 1'b0;
      end
      if (state == START || state == RUN) begin
        cnt <= cnt_inc;
        if (to_set) to_flag <= 1'b1;
      end
      if (state == RESP && io.resp_ready) job_cnt <= job_cnt + 1'b1;
    end
  end

  assign io.core_arg     = arg_q;
  assign io.resp_id      = cur_id;
  assign io.resp_cycles  = cnt;
  assign io.resp_timeout = to_flag;
  assign io.job_count    = job_cnt;

endmodule

// File: tb/tb_fast_accel_job_sched.sv
// Directed bench for fast_accel_job_sched: round-robin, latency, same-cycle ready/done,
// backpressure, timeout with drain, and asynchronous reset mid-job.
module tb_fast_accel_job_sched;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int TO = 100;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b1;
  always #5 ap_clk = ~ap_clk;

  fast_accel_job_sched_if #(.NUM_REQ(NR), .ARG_W(AW), .CNT_W(CW)) bus ();

  fast_accel_job_sched #(.NUM_REQ(NR), .ARG_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .io       (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int exp_jobs    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_arg(input int i, input logic [31:0] a);
    bus.req_arg[i*AW +: AW] = a;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"},   64'(bus.req_ready), 64'(0));
    chk({tag, "_ap_start"},    64'(bus.core_ap_start), 64'(0));
    chk({tag, "_core_arg"},    64'(bus.core_arg), 64'(0));
    chk({tag, "_resp_valid"},  64'(bus.resp_valid), 64'(0));
    chk({tag, "_resp_id"},     64'(bus.resp_id), 64'(0));
    chk({tag, "_resp_cycles"}, 64'(bus.resp_cycles), 64'(0));
    chk({tag, "_resp_tmo"},    64'(bus.resp_timeout), 64'(0));
    chk({tag, "_busy"},        64'(bus.busy), 64'(0));
    chk({tag, "_job_count"},   64'(bus.job_count), 64'(0));
  endtask

  // Called in START cycle 1; returns just after the edge that samples ap_done.
  task automatic core_run(input int rdy_at, input int done_at);
    for (int c = 1; c <= done_at; c++) begin
      bus.core_ap_ready = (c == rdy_at);
      bus.core_ap_done  = (c == done_at);
      #1;
      chk("ap_start_level", 64'(bus.core_ap_start), 64'(c <= rdy_at));
      chk("no_grant_busy",  64'(bus.req_ready), 64'(0));
      tick();
    end
    bus.core_ap_ready = 1'b0;
    bus.core_ap_done  = 1'b0;
  endtask

  task automatic finish_resp(input int id, input int cyc, input logic tmo);
    #1;
    chk("resp_valid",   64'(bus.resp_valid), 64'(1));
    chk("resp_id",      64'(bus.resp_id), 64'(id));
    chk("resp_cycles",  64'(bus.resp_cycles), 64'(cyc));
    chk("resp_timeout", 64'(bus.resp_timeout), 64'(tmo));
    chk("resp_no_gnt",  64'(bus.req_ready), 64'(0));
    chk("jobs_before",  64'(bus.job_count), 64'(exp_jobs));
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    exp_jobs++;
    chk("jobs_after",   64'(bus.job_count), 64'(exp_jobs));
    chk("resp_dropped", 64'(bus.resp_valid), 64'(0));
  endtask

  initial begin
    bus.req_valid     = '0;
    bus.req_arg       = '0;
    bus.core_ap_ready = 1'b0;
    bus.core_ap_done  = 1'b0;
    bus.core_ap_idle  = 1'b0;
    bus.resp_ready    = 1'b0;

    #1 ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 chk_zero("reset");
    @(negedge ap_rst_n or negedge ap_clk);
    ap_rst_n = 1'b1;
    tick();

    // round-robin with all four requesters permanently valid
    bus.req_valid = 4'hF;
    for (int i = 0; i < NR; i++) set_arg(i, 32'h1000 + i);
    for (int g = 0; g < 5; g++) begin
      #1 chk("rr_grant", 64'(bus.req_ready), 64'(1 << (g % NR)));
      tick();
      chk("rr_core_arg", 64'(bus.core_arg), 64'(32'h1000 + (g % NR)));
      chk("rr_busy",     64'(bus.busy), 64'(1));
      core_run(1, 5);
      finish_resp(g % NR, 5, 1'b0);
    end
    bus.req_valid = '0;

    // single job on requester 2, ready after one cycle, 20-cycle latency
    bus.req_valid = 4'b0100;
    set_arg(2, 32'hDEAD_BEEF);
    #1 chk("single_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    chk("single_arg", 64'(bus.core_arg), 64'(32'hDEAD_BEEF));
    core_run(2, 20);
    chk("single_arg_held", 64'(bus.core_arg), 64'(32'hDEAD_BEEF));
    finish_resp(2, 20, 1'b0);

    // ap_ready and ap_done together in the first START cycle
    bus.req_valid = 4'b0010;
    set_arg(1, 32'h5555_AAAA);
    #1 chk("same_grant", 64'(bus.req_ready), 64'(4'b0010));
    tick();
    bus.req_valid = '0;
    core_run(1, 1);
    chk("same_start_low", 64'(bus.core_ap_start), 64'(0));
    finish_resp(1, 1, 1'b0);

    // backpressure: record held for 10 cycles while requester 0 waits
    bus.req_valid = 4'b1000;
    set_arg(3, 32'h3333_4444);
    #1 chk("bp_grant", 64'(bus.req_ready), 64'(4'b1000));
    tick();
    bus.req_valid = 4'b0001;
    core_run(1, 3);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_valid",  64'(bus.resp_valid), 64'(1));
      chk("bp_id",     64'(bus.resp_id), 64'(3));
      chk("bp_cycles", 64'(bus.resp_cycles), 64'(3));
      chk("bp_no_gnt", 64'(bus.req_ready), 64'(0));
      chk("bp_jobs",   64'(bus.job_count), 64'(exp_jobs));
      tick();
    end
    finish_resp(3, 3, 1'b0);
    #1 chk("bp_next_grant", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    core_run(1, 2);
    finish_resp(0, 2, 1'b0);

    // timeout: core takes its inputs but never completes
    bus.req_valid = 4'b0100;
    set_arg(2, 32'h7777_0002);
    #1 chk("to_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = 4'b0001;
    for (int c = 1; c <= TO; c++) begin
      bus.core_ap_ready = (c == 1);
      #1 chk("to_not_yet", 64'(bus.resp_valid), 64'(0));
      tick();
    end
    bus.core_ap_ready = 1'b0;
    finish_resp(2, TO, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_busy",   64'(bus.busy), 64'(1));
      chk("drain_no_gnt", 64'(bus.req_ready), 64'(0));
      tick();
    end
    bus.core_ap_idle = 1'b1;
    tick();
    bus.core_ap_idle = 1'b0;
    #1;
    chk("drain_exit",  64'(bus.busy), 64'(0));
    chk("drain_grant", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    // done in the very cycle the counter reaches the limit is a normal completion
    core_run(1, TO);
    finish_resp(0, TO, 1'b0);

    // asynchronous reset while the core is running
    bus.req_valid = 4'b0100;
    set_arg(2, 32'hCAFE_0002);
    #1 chk("ar_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid     = '0;
    bus.core_ap_ready = 1'b1;
    tick();
    bus.core_ap_ready = 1'b0;
    tick();
    tick();
    chk("ar_busy_before", 64'(bus.busy), 64'(1));
    #1 ap_rst_n = 1'b0;
    #1 chk_zero("async_rst");
    exp_jobs = 0;
    bus.req_valid = 4'hF;
    for (int i = 0; i < NR; i++) set_arg(i, 32'hA000 + i);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1 chk("post_rst_grant", 64'(bus.req_ready), 64'(4'b0001));
    tick();
    bus.req_valid = '0;
    chk("post_rst_arg", 64'(bus.core_arg), 64'(32'hA000));
    core_run(1, 2);
    finish_resp(0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fast_accel_job_sched.md
Name: fast_accel_job_sched

Overview:
- Job scheduler in front of the fast_accel HLS core (ap_ctrl_hs handshake).
- Accepts job requests from NUM_REQ requesters and arbitrates between them round-robin.
- Sequences exactly one core invocation at a time: ap_start, then ap_ready, then ap_done.
- Returns per-job completion records: requester id, cycle latency, timeout flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ARG_W, 32, width of the per-job argument word forwarded to the core
- CNT_W, 16, width of the latency counter and the job counter
- TIMEOUT, 50000, cycles from start after which the job is reported as timed out

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester job request
- req_arg  in  NUM_REQ*ARG_W  per-requester argument; slice i belongs to requester i
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- core_ap_start  out  1  core start
- core_ap_ready  in  1  core accepted its inputs
- core_ap_done  in  1  core finished
- core_ap_idle  in  1  core idle
- core_arg  out  ARG_W  argument held stable for the whole job
- resp_valid  out  1  completion record valid
- resp_ready  in  1  completion record consumed
- resp_id  out  $clog2(NUM_REQ)  requester of the completed job
- resp_cycles  out  CNT_W  job latency in cycles, saturating
- resp_timeout  out  1  job exceeded TIMEOUT
- busy  out  1  state is not IDLE
- job_count  out  CNT_W  completed jobs, wraps

Behaviour:
- Reset (async assert, sync deassert by design):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including core_arg, resp_* and job_count.
- States:
  - IDLE: if any req_valid is set, grant one requester this cycle.
    - Grant = lowest index i >= rr_ptr with req_valid[i], else lowest index overall.
    - req_ready[i]=1 for this cycle only; capture req_arg slice i into core_arg and i into cur_id.
    - rr_ptr <= (i+1) mod NUM_REQ.
    - Next state START; core_ap_start=1 from the next cycle.
  - START: hold core_ap_start=1 until the first cycle with core_ap_ready=1.
    - core_ap_start drops in the cycle after ap_ready.
    - If core_ap_done is also 1 in that cycle, go directly to RESP; otherwise go to RUN.
  - RUN: wait for core_ap_done=1, then go to RESP.
  - RESP: resp_valid=1 with resp_id/resp_cycles/resp_timeout stable until resp_ready=1.
    - In the handshake cycle: job_count++, then go to DRAIN if a timeout is pending, else IDLE.
  - DRAIN: wait for core_ap_done=1 (discarded) or core_ap_idle=1, then go to IDLE.
- Latency counter:
  - Cleared when the request is granted.
  - Increments every cycle in START and RUN.
  - The cycle in which ap_done is sampled is counted.
  - Saturates at 2^CNT_W-1.
- Timeout:
  - In START or RUN, when the counter reaches TIMEOUT without ap_done, set resp_timeout=1, go to RESP and mark timeout pending.
  - core_ap_start drops on timeout.
  - ap_done arriving in the same cycle as the counter hitting TIMEOUT wins: the job is not a timeout.
- Argument and id: core_arg and cur_id change only at grant.
- Request rules:
  - A requester keeps req_valid and req_arg until it sees req_ready.
  - Deasserting req_valid before the grant withdraws the request without error.
- No new grant while busy; requests wait.
- resp_valid may stay high indefinitely: backpressure stalls the scheduler in RESP.
- Reset mid-job returns to IDLE immediately. The core is expected to be reset by the same ap_rst_n.

Decomposition:
- Package fast_accel_sched_pkg:
  - state enum {IDLE, START, RUN, RESP, DRAIN}
  - default widths
  - function clog2_min1 (returns 1 for NUM_REQ=1)
- Sub-module fast_accel_rr_arb: combinational round-robin grant from (req_valid, rr_ptr) to a one-hot grant plus an encoded index. The pointer register stays in the parent.

Test Plan:
- Single job: req_valid[2]=1, arg=0xDEAD_BEEF; core ready after 1 cycle, done 20 cycles after start -> req_ready[2] pulses once, core_arg=0xDEADBEEF, resp_id=2, resp_cycles=20, resp_timeout=0, job_count=1.
- Round-robin: all four requesters valid continuously, core done 5 cycles after start -> grant order 0,1,2,3,0; each req_ready exactly one cycle; no grant while busy.
- Same-cycle ready and done: core asserts ap_ready and ap_done together in the first START cycle -> direct transition to RESP, resp_cycles=1, core_ap_start low the next cycle.
- Timeout: TIMEOUT=100, core never asserts done -> resp_timeout=1, resp_cycles=100; DRAIN until ap_idle=1; the next request is granted only afterwards.
- Backpressure: resp_ready=0 for 10 cycles -> resp fields stable, other requests not granted, job_count increments only at the handshake.
- Async reset asserted in RUN -> all outputs 0 without waiting for a clock edge; after release, rr_ptr=0 and requester 0 is granted first.
